writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  MEM/WB stage producer for the register file write port (writeRegister/writeData/regWrite).
//  Accepts retired instructions from MEM, waits on multi-cycle load data, extracts and extends sub-word
//  loads, then issues exactly one single-cycle register-file write. Mirrors each write and any pending
//  load destination to the forwarding/hazard logic.
// PARAMETERS
//  TIMEOUT    16  max cycles in WAIT_LOAD without loadDataValid before the load is abandoned
//  TIMEOUT_W  5   width of timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  inValid          in   1   MEM presents an instruction this cycle
//  inReady          out  1   unit accepts; transfer when inValid && inReady
//  inRegWrite       in   1   instruction writes a register
//  inMemToReg       in   1   1 = load (data from loadData), 0 = ALU result
//  inLoadSize       in   2   00 byte, 01 half, 10 word (11 treated as word)
//  inLoadUnsigned   in   1   1 = zero-extend, 0 = sign-extend
//  inWriteRegister  in   5   destination register
//  aluResult        in   32  ALU result; for loads, the effective address
//  loadData         in   32  aligned memory word
//  loadDataValid    in   1   loadData valid this cycle
//  flush            in   1   synchronous cancel of un-committed work
//  regWrite         out  1   register-file write strobe
//  writeRegister    out  5   register-file write address
//  writeData        out  32  register-file write data
//  pendingLoad      out  1   a load is waiting for data
//  pendingRegister  out  5   destination of the pending load
//  loadError        out  1   sticky; set on load timeout, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; regWrite, writeRegister, writeData, pendingLoad, pendingRegister, loadError,
//   timeout counter all 0. Reset in any state (incl. mid-WAIT_LOAD) discards work; no write issued.
//  States: IDLE, WAIT_LOAD, WRITE. inReady = 1 in IDLE and WRITE, 0 in WAIT_LOAD.
//  Accept (IDLE or WRITE, transfer, flush=0):
//   inRegWrite=0 or inWriteRegister=0 -> bubble, next IDLE, no write, no pending.
//   inMemToReg=0 -> latch aluResult and dest, next WRITE.
//   inMemToReg=1 -> latch dest/size/unsigned/aluResult[1:0], clear counter, next WAIT_LOAD;
//    pendingLoad=1, pendingRegister=dest from next cycle.
//  No transfer in WRITE or IDLE -> next IDLE. flush=1 on accept cycle: input ignored.
//  WAIT_LOAD: loadDataValid=1 -> extract/extend, next WRITE, pendingLoad=0.
//   Else counter++; counter reaching TIMEOUT -> loadError=1, drop write, next IDLE, pendingLoad=0.
//   flush=1 -> next IDLE, pendingLoad=0, no write; flush has priority over loadDataValid same cycle.
//  WRITE: regWrite=1 for exactly this cycle with latched register/data; already committed, flush does
//   not cancel it. Back-to-back ALU instructions give regWrite high on consecutive cycles.
//  Latency: accept at edge N -> regWrite high in cycle N+1 (ALU); loadDataValid at edge M -> write M+1.
//  writeRegister/writeData hold last value when regWrite=0.
//  Extraction, big-endian, offset = aluResult[1:0]:
//   byte: off 0..3 -> bits [31:24],[23:16],[15:8],[7:0]; half: off[1]=0 -> [31:16], 1 -> [15:0],
//   off[0] ignored; word: offset ignored. Extend to 32 bits by sign or zero per inLoadUnsigned.
//  Register 0 is never written: regWrite never asserts with writeRegister=0.
// TESTING
//  ALU: accept dest=8, aluResult=0x00001234 -> next cycle regWrite=1, writeRegister=8, writeData=0x1234.
//  LB signed, aluResult=0x101, loadData=0x11F02233 after 3 cycles -> inReady=0 for 3 cycles,
//   pendingRegister=9, then writeData=0xFFFFFFF0; same with LBU -> 0x000000F0.
//  LH signed, offset 2, loadData=0x1234_8001 -> writeData=0xFFFF8001; LW -> 0x12348001.
//  No loadDataValid for 16 cycles -> loadError=1, regWrite never asserts, back to IDLE, inReady=1.
//  dest=0 ALU instruction -> no regWrite; flush in WAIT_LOAD with loadDataValid same cycle -> no write.
//  rst_n low mid-WAIT_LOAD -> all outputs 0 immediately, IDLE; later loadDataValid ignored.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Bundle of the MEM-side handshake, the register-file write port and the
// hazard/forwarding mirror signals of the writeback unit.
interface writeback_unit_if;
    logic        inValid;
    logic        inReady;
    logic        inRegWrite;
    logic        inMemToReg;
    logic [1:0]  inLoadSize;
    logic        inLoadUnsigned;
    logic [4:0]  inWriteRegister;
    logic [31:0] aluResult;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        flush;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        pendingLoad;
    logic [4:0]  pendingRegister;
    logic        loadError;

    // Pipeline / memory side: drives instructions, load data and flush, observes the results
    modport master (
        output inValid, inRegWrite, inMemToReg, inLoadSize, inLoadUnsigned,
               inWriteRegister, aluResult, loadData, loadDataValid, flush,
        input  inReady, regWrite, writeRegister, writeData, pendingLoad,
               pendingRegister, loadError
    );

    // Writeback unit side
    modport slave (
        input  inValid, inRegWrite, inMemToReg, inLoadSize, inLoadUnsigned,
               inWriteRegister, aluResult, loadData, loadDataValid, flush,
        output inReady, regWrite, writeRegister, writeData, pendingLoad,
               pendingRegister, loadError
    );
endinterface

// File: rtl/writeback_unit.sv
// MEM/WB writeback unit: accepts retired instructions, waits for multi-cycle
// load data, extracts and extends sub-word loads (big-endian) and issues one
// single-cycle register-file write per instruction. Register 0 is never written.
// TIMEOUT_W must be wide enough that 2**TIMEOUT_W > TIMEOUT.
module writeback_unit #(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Latched context of the load currently waiting for data
    logic [4:0]           r_loadDest;
    logic [1:0]           r_loadSize;
    logic                 r_loadUnsigned;
    logic [1:0]           r_loadOffset;
    logic [TIMEOUT_W-1:0] r_count;

    // Register-file write port; holds its last value while regWrite is low
    logic [4:0]           r_writeRegister;
    logic [31:0]          r_writeData;
    logic                 r_loadError;

    logic                 w_ready;
    logic                 w_transfer;
    logic                 w_bubble;
    logic                 w_acceptAlu;
    logic                 w_acceptLoad;
    logic                 w_loadDone;
    logic                 w_timeoutHit;
    logic [TIMEOUT_W-1:0] w_countNext;
    logic [31:0]          w_extracted;
    logic                 w_regWrite;
    logic                 w_pendingLoad;
    logic [4:0]           w_pendingRegister;

    // Big-endian sub-word selection followed by sign or zero extension
    function automatic logic [31:0] extractLoad(
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic        isUnsigned
    );
        logic [7:0]  selByte;
        logic [15:0] selHalf;
        logic [31:0] result;
        case (offset)
            2'd0:    selByte = data[31:24];
            2'd1:    selByte = data[23:16];
            2'd2:    selByte = data[15:8];
            default: selByte = data[7:0];
        endcase
        selHalf = offset[1] ? data[15:0] : data[31:16];
        case (size)
            2'b00:   result = isUnsigned ? {24'b0, selByte} : {{24{selByte[7]}}, selByte};
            2'b01:   result = isUnsigned ? {16'b0, selHalf} : {{16{selHalf[15]}}, selHalf};
            default: result = data;
        endcase
        return result;
    endfunction

    // Decode of the input handshake and of the load-wait events
    always_comb begin
        w_transfer   = bus.inValid && w_ready && !bus.flush;
        w_bubble     = !bus.inRegWrite || (bus.inWriteRegister == 5'd0);
        w_acceptAlu  = w_transfer && !w_bubble && !bus.inMemToReg;
        w_acceptLoad = w_transfer && !w_bubble && bus.inMemToReg;
        w_countNext  = r_count + TIMEOUT_W'(1);
        w_loadDone   = (r_state == WAIT_LOAD) && !bus.flush && bus.loadDataValid;
        w_timeoutHit = (r_state == WAIT_LOAD) && !bus.flush && !bus.loadDataValid &&
                       (w_countNext == TIMEOUT_W'(TIMEOUT));
        w_extracted  = extractLoad(bus.loadData, r_loadSize, r_loadOffset, r_loadUnsigned);
    end

    // State register; reset abandons any work in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; in WAIT_LOAD flush beats load data, which beats the timeout
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE, WRITE: begin
                if (w_acceptAlu) begin
                    w_nextState = WRITE;
                end else if (w_acceptLoad) begin
                    w_nextState = WAIT_LOAD;
                end else begin
                    w_nextState = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (bus.flush) begin
                    w_nextState = IDLE;
                end else if (bus.loadDataValid) begin
                    w_nextState = WRITE;
                end else if (w_timeoutHit) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = WAIT_LOAD;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Moore outputs derived from the current state
    always_comb begin
        w_ready           = (r_state != WAIT_LOAD);
        w_regWrite        = (r_state == WRITE);
        w_pendingLoad     = (r_state == WAIT_LOAD);
        w_pendingRegister = w_pendingLoad ? r_loadDest : 5'd0;
    end

    // Capture the load context when a load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadDest     <= 5'd0;
            r_loadSize     <= 2'd0;
            r_loadUnsigned <= 1'b0;
            r_loadOffset   <= 2'd0;
        end else if (w_acceptLoad) begin
            r_loadDest     <= bus.inWriteRegister;
            r_loadSize     <= bus.inLoadSize;
            r_loadUnsigned <= bus.inLoadUnsigned;
            r_loadOffset   <= bus.aluResult[1:0];
        end
    end

    // Count cycles spent waiting for load data; zero whenever not waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == WAIT_LOAD) && (w_nextState == WAIT_LOAD)) begin
            r_count <= w_countNext;
        end else begin
            r_count <= '0;
        end
    end

    // Load the write port only when a write is about to be issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_writeRegister <= 5'd0;
            r_writeData     <= 32'd0;
        end else if (w_acceptAlu) begin
            r_writeRegister <= bus.inWriteRegister;
            r_writeData     <= bus.aluResult;
        end else if (w_loadDone) begin
            r_writeRegister <= r_loadDest;
            r_writeData     <= w_extracted;
        end
    end

    // Sticky error flag for abandoned loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadError <= 1'b0;
        end else if (w_timeoutHit) begin
            r_loadError <= 1'b1;
        end
    end

    assign bus.inReady         = w_ready;
    assign bus.regWrite        = w_regWrite;
    assign bus.writeRegister   = r_writeRegister;
    assign bus.writeData       = r_writeData;
    assign bus.pendingLoad     = w_pendingLoad;
    assign bus.pendingRegister = w_pendingRegister;
    assign bus.loadError       = r_loadError;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, self-checking bench for writeback_unit. Inputs change 1ns after
// the rising edge and outputs are compared before the next rising edge.
module tb_writeback_unit;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    writeback_unit_if bus ();

    writeback_unit #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1ns after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.inValid         = 1'b0;
        bus.inRegWrite      = 1'b0;
        bus.inMemToReg      = 1'b0;
        bus.inLoadSize      = 2'b00;
        bus.inLoadUnsigned  = 1'b0;
        bus.inWriteRegister = 5'd0;
        bus.aluResult       = 32'd0;
        bus.loadData        = 32'd0;
        bus.loadDataValid   = 1'b0;
        bus.flush           = 1'b0;
    endtask

    task automatic applyStimulus(input logic regWr, input logic memToReg, input logic [1:0] size,
                                 input logic uns, input logic [4:0] dest, input logic [31:0] alu);
        bus.inValid         = 1'b1;
        bus.inRegWrite      = regWr;
        bus.inMemToReg      = memToReg;
        bus.inLoadSize      = size;
        bus.inLoadUnsigned  = uns;
        bus.inWriteRegister = dest;
        bus.aluResult       = alu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleInputs();
        #3;
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_regWrite: got %b expected 0", bus.regWrite); end
        checks++; if (bus.writeRegister !== 5'd0) begin errors++; $display("[TB] FAIL rst_writeRegister: got %0d expected 0", bus.writeRegister); end
        checks++; if (bus.writeData !== 32'd0) begin errors++; $display("[TB] FAIL rst_writeData: got %h expected 0", bus.writeData); end
        checks++; if (bus.pendingLoad !== 1'b0) begin errors++; $display("[TB] FAIL rst_pendingLoad: got %b expected 0", bus.pendingLoad); end
        checks++; if (bus.pendingRegister !== 5'd0) begin errors++; $display("[TB] FAIL rst_pendingRegister: got %0d expected 0", bus.pendingRegister); end
        checks++; if (bus.loadError !== 1'b0) begin errors++; $display("[TB] FAIL rst_loadError: got %b expected 0", bus.loadError); end
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_inReady: got %b expected 1", bus.inReady); end
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_alu();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 32'h0000_1234);
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL alu_inReady: got %b expected 1", bus.inReady); end
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b1) begin errors++; $display("[TB] FAIL alu_regWrite: got %b expected 1", bus.regWrite); end
        checks++; if (bus.writeRegister !== 5'd8) begin errors++; $display("[TB] FAIL alu_writeRegister: got %0d expected 8", bus.writeRegister); end
        checks++; if (bus.writeData !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_writeData: got %h expected 00001234", bus.writeData); end
        cycle();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL alu_single_cycle: got %b expected 0", bus.regWrite); end
        checks++; if (bus.writeRegister !== 5'd8) begin errors++; $display("[TB] FAIL alu_hold_register: got %0d expected 8", bus.writeRegister); end
        checks++; if (bus.writeData !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_hold_data: got %h expected 00001234", bus.writeData); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 32'hAAAA_0005);
        cycle();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 32'hBBBB_0006);
        checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd5 || bus.writeData !== 32'hAAAA_0005) begin errors++; $display("[TB] FAIL b2b_first: got %b/%0d/%h expected 1/5/aaaa0005", bus.regWrite, bus.writeRegister, bus.writeData); end
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_in_write: got %b expected 1", bus.inReady); end
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd6 || bus.writeData !== 32'hBBBB_0006) begin errors++; $display("[TB] FAIL b2b_second: got %b/%0d/%h expected 1/6/bbbb0006", bus.regWrite, bus.writeRegister, bus.writeData); end
        cycle();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 0", bus.regWrite); end
    endtask

    // LB/LBU from the worked example, with data arriving in the third wait cycle
    task automatic test_load_byte();
        logic [31:0] expData [2];
        logic [4:0]  expHold [2];
        expData[0] = 32'hFFFF_FFF0;
        expData[1] = 32'h0000_00F0;
        expHold[0] = 5'd6;
        expHold[1] = 5'd9;
        for (int u = 0; u < 2; u++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, u[0], 5'd9, 32'h0000_0101);
            cycle();
            idleInputs();
            checks++; if (bus.pendingLoad !== 1'b1 || bus.pendingRegister !== 5'd9) begin errors++; $display("[TB] FAIL lb%0d_pending: got %b/%0d expected 1/9", u, bus.pendingLoad, bus.pendingRegister); end
            checks++; if (bus.writeRegister !== expHold[u]) begin errors++; $display("[TB] FAIL lb%0d_hold_during_wait: got %0d expected %0d", u, bus.writeRegister, expHold[u]); end
            for (int w = 0; w < 3; w++) begin
                checks++; if (bus.inReady !== 1'b0 || bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL lb%0d_wait%0d: got ready=%b wr=%b expected 0/0", u, w, bus.inReady, bus.regWrite); end
                if (w == 2) begin
                    bus.loadData      = 32'h11F0_2233;
                    bus.loadDataValid = 1'b1;
                end
                cycle();
            end
            idleInputs();
            checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd9) begin errors++; $display("[TB] FAIL lb%0d_write: got %b/%0d expected 1/9", u, bus.regWrite, bus.writeRegister); end
            checks++; if (bus.writeData !== expData[u]) begin errors++; $display("[TB] FAIL lb%0d_data: got %h expected %h", u, bus.writeData, expData[u]); end
            checks++; if (bus.pendingLoad !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL lb%0d_after: got pend=%b ready=%b expected 0/1", u, bus.pendingLoad, bus.inReady); end
            cycle();
        end
    endtask

    // Table of size/sign/offset cases, each with data in the first wait cycle
    task automatic test_load_sizes();
        logic [1:0]  vSize [10];
        logic        vUns  [10];
        logic [31:0] vAddr [10];
        logic [31:0] vData [10];
        logic [31:0] vExp  [10];
        vSize[0] = 2'b00; vUns[0] = 1'b0; vAddr[0] = 32'h200; vData[0] = 32'h11F0_2233; vExp[0] = 32'h0000_0011;
        vSize[1] = 2'b00; vUns[1] = 1'b0; vAddr[1] = 32'h203; vData[1] = 32'h11F0_22B3; vExp[1] = 32'hFFFF_FFB3;
        vSize[2] = 2'b00; vUns[2] = 1'b1; vAddr[2] = 32'h203; vData[2] = 32'h11F0_22B3; vExp[2] = 32'h0000_00B3;
        vSize[3] = 2'b00; vUns[3] = 1'b0; vAddr[3] = 32'h202; vData[3] = 32'h11F0_2233; vExp[3] = 32'h0000_0022;
        vSize[4] = 2'b01; vUns[4] = 1'b0; vAddr[4] = 32'h302; vData[4] = 32'h1234_8001; vExp[4] = 32'hFFFF_8001;
        vSize[5] = 2'b01; vUns[5] = 1'b1; vAddr[5] = 32'h302; vData[5] = 32'h1234_8001; vExp[5] = 32'h0000_8001;
        vSize[6] = 2'b01; vUns[6] = 1'b0; vAddr[6] = 32'h301; vData[6] = 32'h8234_0001; vExp[6] = 32'hFFFF_8234;
        vSize[7] = 2'b01; vUns[7] = 1'b0; vAddr[7] = 32'h303; vData[7] = 32'h1234_8001; vExp[7] = 32'hFFFF_8001;
        vSize[8] = 2'b10; vUns[8] = 1'b0; vAddr[8] = 32'h302; vData[8] = 32'h1234_8001; vExp[8] = 32'h1234_8001;
        vSize[9] = 2'b11; vUns[9] = 1'b1; vAddr[9] = 32'h301; vData[9] = 32'h8765_4321; vExp[9] = 32'h8765_4321;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, vSize[i], vUns[i], 5'(i + 16), vAddr[i]);
            cycle();
            idleInputs();
            bus.loadData      = vData[i];
            bus.loadDataValid = 1'b1;
            cycle();
            idleInputs();
            checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'(i + 16) || bus.writeData !== vExp[i]) begin errors++; $display("[TB] FAIL load_vec%0d: got %b/%0d/%h expected 1/%0d/%h", i, bus.regWrite, bus.writeRegister, bus.writeData, i + 16, vExp[i]); end
            cycle();
        end
    endtask

    task automatic test_bubbles();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd0, 32'hDEAD_0000);
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL dest0_alu: got %b expected 0", bus.regWrite); end
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 5'd7, 32'hDEAD_0007);
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL noregwrite: got %b expected 0", bus.regWrite); end
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0000_0400);
        cycle();
        idleInputs();
        checks++; if (bus.pendingLoad !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL dest0_load: got pend=%b ready=%b expected 0/1", bus.pendingLoad, bus.inReady); end
        cycle();
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd25) begin errors++; $display("[TB] FAIL bubble_hold: got %b/%0d expected 0/25", bus.regWrite, bus.writeRegister); end
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd12, 32'h0000_0C0C);
        bus.flush = 1'b1;
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL flush_accept: got %b expected 0", bus.regWrite); end
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd11, 32'h0000_0500);
        cycle();
        idleInputs();
        bus.flush         = 1'b1;
        bus.loadDataValid = 1'b1;
        bus.loadData      = 32'h1111_2222;
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b0 || bus.pendingLoad !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL flush_wait: got wr=%b pend=%b ready=%b expected 0/0/1", bus.regWrite, bus.pendingLoad, bus.inReady); end
        cycle();
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_late: got %b expected 0", bus.regWrite); end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd13, 32'h0000_0055);
        cycle();
        idleInputs();
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd13 || bus.writeData !== 32'h55) begin errors++; $display("[TB] FAIL flush_in_write: got %b/%0d/%h expected 1/13/00000055", bus.regWrite, bus.writeRegister, bus.writeData); end
        cycle();
        idleInputs();
    endtask

    // Data arriving in the last allowed wait cycle still completes normally
    task automatic test_timeout_boundary();
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd15, 32'h0000_0000);
        cycle();
        idleInputs();
        repeat (15) cycle();
        checks++; if (bus.pendingLoad !== 1'b1 || bus.loadError !== 1'b0) begin errors++; $display("[TB] FAIL boundary_wait: got pend=%b err=%b expected 1/0", bus.pendingLoad, bus.loadError); end
        bus.loadData      = 32'hCAFE_F00D;
        bus.loadDataValid = 1'b1;
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b1 || bus.writeData !== 32'hCAFE_F00D || bus.loadError !== 1'b0) begin errors++; $display("[TB] FAIL boundary_write: got wr=%b data=%h err=%b expected 1/cafef00d/0", bus.regWrite, bus.writeData, bus.loadError); end
        cycle();
    endtask

    task automatic test_timeout();
        logic sawWrite;
        sawWrite = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd10, 32'h0000_0800);
        cycle();
        idleInputs();
        repeat (15) begin
            if (bus.regWrite !== 1'b0) sawWrite = 1'b1;
            cycle();
        end
        checks++; if (bus.pendingLoad !== 1'b1 || bus.loadError !== 1'b0 || bus.inReady !== 1'b0) begin errors++; $display("[TB] FAIL timeout_15: got pend=%b err=%b ready=%b expected 1/0/0", bus.pendingLoad, bus.loadError, bus.inReady); end
        cycle();
        checks++; if (bus.loadError !== 1'b1 || bus.pendingLoad !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL timeout_16: got err=%b pend=%b ready=%b expected 1/0/1", bus.loadError, bus.pendingLoad, bus.inReady); end
        if (bus.regWrite !== 1'b0) sawWrite = 1'b1;
        bus.loadDataValid = 1'b1;
        bus.loadData      = 32'h7777_7777;
        cycle();
        idleInputs();
        if (bus.regWrite !== 1'b0) sawWrite = 1'b1;
        checks++; if (sawWrite !== 1'b0) begin errors++; $display("[TB] FAIL timeout_nowrite: got %b expected 0", sawWrite); end
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 5'd3, 32'h0000_0003);
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd3 || bus.loadError !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got wr=%b reg=%0d err=%b expected 1/3/1", bus.regWrite, bus.writeRegister, bus.loadError); end
        cycle();
    endtask

    task automatic test_reset_mid_wait();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 5'd14, 32'h0000_0600);
        cycle();
        idleInputs();
        checks++; if (bus.pendingLoad !== 1'b1 || bus.pendingRegister !== 5'd14) begin errors++; $display("[TB] FAIL rstwait_pending: got %b/%0d expected 1/14", bus.pendingLoad, bus.pendingRegister); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pendingLoad !== 1'b0 || bus.pendingRegister !== 5'd0 || bus.inReady !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_state: got pend=%b preg=%0d ready=%b expected 0/0/1", bus.pendingLoad, bus.pendingRegister, bus.inReady); end
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd0 || bus.writeData !== 32'd0 || bus.loadError !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_outputs: got %b/%0d/%h err=%b expected 0/0/0 err=0", bus.regWrite, bus.writeRegister, bus.writeData, bus.loadError); end
        cycle();
        rst_n = 1'b1;
        bus.loadDataValid = 1'b1;
        bus.loadData      = 32'h9999_9999;
        cycle();
        idleInputs();
        checks++; if (bus.regWrite !== 1'b0 || bus.writeData !== 32'd0) begin errors++; $display("[TB] FAIL rstwait_stray_data: got %b/%h expected 0/00000000", bus.regWrite, bus.writeData); end
        cycle();
    endtask

    // Run every scenario in order, then report
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_byte();
        test_load_sizes();
        test_bubbles();
        test_flush();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
